alu_fu: RTL

- Parametrised, pipelined scalar ALU functional unit for the CGRA s_tile scalar FU slot.
- Successor to the single-op adder FU: multiple operations, configurable width and pipeline depth, valid/ready handshake with backpressure.
- Keeps the existing on_off enable semantics.
- Sits between the tile operand crossbar (upstream) and the tile result register/router (downstream).

---
 rtl/alu_fu_pkg.sv | 19 +
 rtl/alu_fu_core.sv | 67 ++++++
 rtl/alu_fu.sv | 69 ++++++
 3 files changed

// File: rtl/alu_fu_pkg.sv
// Shared types and limits for the alu_fu scalar functional unit.
package alu_fu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  localparam int MIN_WIDTH  = 8;
  localparam int MAX_WIDTH  = 64;
  localparam int MAX_STAGES = 4;

endpackage

// File: rtl/alu_fu_core.sv
// Combinational ALU datapath for alu_fu.
// Define ALU_FU_SATURATE_EN to clamp ADD/SUB results on signed overflow.
module alu_fu_core
  import alu_fu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[SHW-1:0];

`ifdef ALU_FU_SATURATE_EN
  logic [WIDTH-1:0] max_pos;
  logic [WIDTH-1:0] min_neg;
  logic             add_ovf;
  logic             sub_ovf;

  assign max_pos = {1'b0, {(WIDTH-1){1'b1}}};
  assign min_neg = {1'b1, {(WIDTH-1){1'b0}}};
  // Overflow direction always follows the sign of a.
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  assign add_res = add_ovf ? (a[WIDTH-1] ? min_neg : max_pos) : sum[WIDTH-1:0];
  assign sub_res = sub_ovf ? (a[WIDTH-1] ? min_neg : max_pos) : diff[WIDTH-1:0];
`else
  assign add_res = sum[WIDTH-1:0];
  assign sub_res = diff[WIDTH-1:0];
`endif

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      ALU_ADD: begin
        result = add_res;
        carry  = sum[WIDTH];
      end
      ALU_SUB: begin
        result = sub_res;
        carry  = ~diff[WIDTH];
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL: result = a << shamt;
      ALU_SRL: result = a >> shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_fu.sv
// Pipelined scalar ALU FU with valid/ready handshake and on_off flush.
// Optional build macro: ALU_FU_SATURATE_EN (signed saturation on ADD/SUB).
module alu_fu
  import alu_fu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             on_off,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             carry,
  output logic             ack
);

  logic [WIDTH-1:0]  core_result;
  logic              core_carry;
  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_carry;
  logic [WIDTH-1:0]  stage_data [STAGES];
  logic              advance;

  alu_fu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op    (alu_op_e'(op)),
    .a     (a),
    .b     (b),
    .result(core_result),
    .carry (core_carry)
  );

  assign out_valid = on_off && stage_valid[STAGES-1];
  // Global stall: nothing moves while the tail result waits on downstream.
  assign in_ready  = reset && on_off && !(out_valid && !out_ready);
  assign advance   = in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_valid <= '0;
      stage_carry <= '0;
      for (int k = 0; k < STAGES; k++) stage_data[k] <= '0;
    end else if (!on_off) begin
      stage_valid <= '0;
    end else if (advance) begin
      stage_valid[0] <= in_valid;
      stage_carry[0] <= core_carry;
      stage_data[0]  <= core_result;
      for (int k = 1; k < STAGES; k++) begin
        stage_valid[k] <= stage_valid[k-1];
        stage_carry[k] <= stage_carry[k-1];
        stage_data[k]  <= stage_data[k-1];
      end
    end
  end

  assign c     = out_valid ? stage_data[STAGES-1] : '0;
  assign carry = out_valid && stage_carry[STAGES-1];
  assign ack   = out_valid && out_ready;

endmodule
